// File: rtl/tw_seq_pkg.sv
// tw_seq_pkg: shared FSM state type, delay limit and bit-reversal helper
// for the per-stage twiddle address sequencer.
package tw_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   localparam int unsigned MAX_DELAY_BROM = 8;

   // Reverses the low 'width' bits of v; bits at and above 'width' read as zero.
   function automatic logic [31:0] bit_rev(input logic [31:0] v, input int unsigned width);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < width) r[5'(i)] = v[5'(width - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/tw_seq_dly.sv
// tw_seq_dly: parameterised DEPTH-deep shift register of 2-bit (valid, one)
// entries with synchronous clear to CLR_VAL.
module tw_seq_dly #(
   parameter int unsigned DEPTH   = 2,
   parameter logic [1:0]  CLR_VAL = 2'b01
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [1:0] din,
   output logic [1:0] dout
);

   logic [DEPTH-1:0][1:0] sr;

   if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk) begin
         if (clr) sr <= CLR_VAL;
         else     sr <= din;
      end
   end else begin : g_many
      always_ff @(posedge clk) begin
         if (clr) sr <= {DEPTH{CLR_VAL}};
         else     sr <= {sr[DEPTH-2:0], din};
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/tw_addr_seq.sv
// tw_addr_seq: twiddle ROM address sequencer for one radix-2 SDF NTT/INTT stage.
// Define TW_ADDR_BITREV_EN to bit-reverse the index for natural-order twiddle ROMs.
module tw_addr_seq
   import tw_seq_pkg::*;
#(
   parameter int unsigned LOGN       = 8,
   parameter int unsigned STAGE      = 1,
   parameter int unsigned DELAY_BROM = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            intt,
   input  logic            in_valid,
   output logic [LOGN-1:0] raddr,
   output logic            tw_valid,
   output logic            tw_one,
   output logic            busy,
   output logic            done
);

   localparam int unsigned     FW       = $clog2(MAX_DELAY_BROM);
   localparam logic [LOGN-1:0] IDX_MASK = LOGN'((64'd1 << (STAGE - 1)) - 64'd1);

   state_t          state, state_nxt;
   logic [LOGN-1:0] smp;
   logic [LOGN-1:0] idx;
   logic [LOGN-1:0] addr_nxt;
   logic            dir;
   logic            mul;
   logic [FW-1:0]   fcnt;
   logic [1:0]      dly_in;
   logic [1:0]      dly_out;

   // Upper address bit selects the inverse half; the mask keeps STAGE==1 at idx=0.
   always_comb begin
      mul = smp[STAGE-1];
      idx = '0;
      if (mul) begin
`ifdef TW_ADDR_BITREV_EN
         idx = LOGN'(bit_rev(32'(smp & IDX_MASK), STAGE - 1));
`else
         idx = smp & IDX_MASK;
`endif
      end
      addr_nxt           = idx;
      addr_nxt[LOGN-1]   = dir;
   end

   always_comb begin
      state_nxt = state;
      dly_in    = 2'b01;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            if (in_valid) begin
               dly_in = {1'b1, ~mul};
               if (smp == '1) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            // The last valid entry is at the delay-line output this cycle.
            if (fcnt == FW'(DELAY_BROM - 1)) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         smp   <= '0;
         dir   <= 1'b0;
         fcnt  <= '0;
         raddr <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= (state == FLUSH) ? fcnt + 1'b1 : '0;
         if (state == IDLE && start) begin
            dir <= intt;
            smp <= '0;
         end
         if (state == RUN && in_valid) begin
            smp   <= smp + 1'b1;
            raddr <= addr_nxt;
         end
      end
   end

   tw_seq_dly #(
      .DEPTH   (DELAY_BROM),
      .CLR_VAL (2'b01)
   ) u_dly (
      .clk  (clk),
      .clr  (rst),
      .din  (dly_in),
      .dout (dly_out)
   );

   assign tw_valid = dly_out[1];
   assign tw_one   = dly_out[0];
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_tw_addr_seq.sv
// tb_tw_addr_seq: two sequencer configurations driven by shared stimulus and
// checked every cycle against a timeline model built from the pass rules.
module tb_tw_addr_seq;

   localparam int unsigned LOGN = 4;
   localparam int unsigned N    = 1 << LOGN;
   localparam int unsigned ST0  = 3;
   localparam int unsigned DL0  = 2;
   localparam int unsigned ST1  = 1;
   localparam int unsigned DL1  = 3;
   localparam int          HMAX = 8192;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic start    = 1'b0;
   logic intt     = 1'b0;
   logic in_valid = 1'b0;

   logic [LOGN-1:0] raddr_o    [2];
   logic            tw_valid_o [2];
   logic            tw_one_o   [2];
   logic            busy_o     [2];
   logic            done_o     [2];

   always #5 clk = ~clk;

   tw_addr_seq #(.LOGN(LOGN), .STAGE(ST0), .DELAY_BROM(DL0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .intt(intt), .in_valid(in_valid),
      .raddr(raddr_o[0]), .tw_valid(tw_valid_o[0]), .tw_one(tw_one_o[0]),
      .busy(busy_o[0]), .done(done_o[0])
   );

   tw_addr_seq #(.LOGN(LOGN), .STAGE(ST1), .DELAY_BROM(DL1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .intt(intt), .in_valid(in_valid),
      .raddr(raddr_o[1]), .tw_valid(tw_valid_o[1]), .tw_one(tw_one_o[1]),
      .busy(busy_o[1]), .done(done_o[1])
   );

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   int          cyc = 0;
   int          rst_cyc = -1000;
   bit          armed = 1'b0;

   // Pass timeline per configuration: accept cycle, beats consumed, done cycle.
   bit              p_on    [2];
   int              p_start [2];
   int              p_done  [2];
   int unsigned     p_beats [2];
   logic            m_dir   [2];
   logic [LOGN-1:0] m_raddr [2];
   bit              pv      [2][HMAX];
   bit              po      [2][HMAX];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
   endtask

   function automatic int unsigned stage_of(input int i);
      return (i == 0) ? ST0 : ST1;
   endfunction

   function automatic int dly_of(input int i);
      return (i == 0) ? int'(DL0) : int'(DL1);
   endfunction

   function automatic bit running(input int i, input int k);
      return p_on[i] && (k > p_start[i]) && (p_done[i] < 0 || k <= p_done[i]);
   endfunction

   // Beat b lies in the multiply half when bit (stage-1) of b is set.
   function automatic bit is_mul(input int unsigned st, input int unsigned b);
      return ((b >> (st - 1)) % 2) == 1;
   endfunction

   function automatic logic [LOGN-1:0] exp_addr(input int unsigned st, input int unsigned b,
                                                input logic d);
      int unsigned lo;
      int unsigned ix;
      lo = b % (1 << (st - 1));
      ix = 0;
      if (is_mul(st, b)) begin
`ifdef TW_ADDR_BITREV_EN
         for (int unsigned j = 0; j + 1 < st; j++)
            if (((lo >> j) % 2) == 1) ix += 1 << (st - 2 - j);
`else
         ix = lo;
`endif
      end
      return LOGN'((d ? N / 2 : 0) + ix);
   endfunction

   task automatic check_outputs(input int i);
      int  k;
      int  d;
      bit  ev;
      bit  eo;
      k = cyc;
      d = dly_of(i);
      if (k - d > rst_cyc && k - d >= 0) begin
         ev = pv[i][k-d];
         eo = po[i][k-d];
      end else begin
         ev = 1'b0;
         eo = 1'b1;
      end
      check($sformatf("d%0d.raddr", i), 32'(raddr_o[i]), 32'(m_raddr[i]));
      check($sformatf("d%0d.tw_valid", i), 32'(tw_valid_o[i]), 32'(ev));
      check($sformatf("d%0d.tw_one", i), 32'(tw_one_o[i]), 32'(eo));
      check($sformatf("d%0d.done", i), 32'(done_o[i]), 32'(p_on[i] && p_done[i] == k));
      if (!(p_on[i] && p_done[i] == k))
         check($sformatf("d%0d.busy", i), 32'(busy_o[i]), 32'(running(i, k)));
   endtask

   task automatic model_update(input int i, input bit s, input bit it, input bit iv, input bit r);
      int k;
      bit beat;
      k = cyc;
      if (r) begin
         p_on[i]    = 1'b0;
         p_done[i]  = -1;
         m_raddr[i] = '0;
         pv[i][k]   = 1'b0;
         po[i][k]   = 1'b1;
         return;
      end
      beat = running(i, k) && iv && (p_beats[i] < N);
      if (s && !running(i, k)) begin
         p_on[i]    = 1'b1;
         p_start[i] = k;
         p_beats[i] = 0;
         p_done[i]  = -1;
         m_dir[i]   = it;
      end
      pv[i][k] = beat;
      po[i][k] = beat ? !is_mul(stage_of(i), p_beats[i]) : 1'b1;
      if (beat) begin
         m_raddr[i] = exp_addr(stage_of(i), p_beats[i], m_dir[i]);
         p_beats[i]++;
         if (p_beats[i] == N) p_done[i] = k + dly_of(i);
      end
   endtask

   task automatic step(input bit s, input bit it, input bit iv, input bit r);
      @(negedge clk);
      if (armed) begin
         check_outputs(0);
         check_outputs(1);
      end
      if (cyc >= HMAX - 1) begin
         $display("FAIL cycle_budget exhausted at cycle %0d", cyc);
         $fatal(1, "cycle budget exhausted");
      end
      rst      = r;
      start    = s;
      intt     = it;
      in_valid = iv;
      if (r) begin
         rst_cyc = cyc;
         armed   = 1'b1;
      end
      model_update(0, s, it, iv, r);
      model_update(1, s, it, iv, r);
      cyc++;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((running(0, cyc) || running(1, cyc)) && n < 100) begin
         step(1'b0, 1'($urandom), 1'($urandom), 1'b0);
         n++;
      end
      if (n >= 100) check("idle_timeout", 32'(busy_o[0] | busy_o[1]), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      bit bub [5];
      bub = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (4) step(1'b0, 1'($urandom), 1'b1, 1'b0);

      // Forward pass, continuous beats.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (16) step(1'b0, 1'b0, 1'b1, 1'b0);
      wait_idle();

      // Inverse pass with intt toggling mid-pass.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 16; j++) step(1'b0, 1'(j % 2), 1'b1, 1'b0);
      wait_idle();

      // Bubble pattern 1,0,1,1,0.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 30; j++) step(1'b0, 1'b0, bub[j % 5], 1'b0);
      wait_idle();

      // Reset on beat 7, then a clean pass.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (7) step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0);
      wait_idle();

      // Start while busy at beat 5.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0);
      wait_idle();

      // Start held high across done: ignored on the done cycle, accepted after.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (24) step(1'b1, 1'b1, 1'b1, 1'b0);
      wait_idle();

      // Free-running random traffic with occasional resets.
      for (int j = 0; j < 1500; j++)
         step(1'($urandom_range(0, 7) == 0), 1'($urandom),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tw_addr_seq.md
Name: tw_addr_seq

Overview:
- Per-stage twiddle address sequencer for one radix-2 SDF NTT/INTT stage.
- Sits in front of that stage's twiddle ROM wrapper. Counts streamed samples of one N-point polynomial and drives the ROM read address.
- Emits a twiddle-valid strobe and a pass-through flag, both delayed by the ROM read latency so they align with ROM dout.
- Provides start/busy/done handshake to the top-level NTT controller.

Parameters:
- LOGN, 8, log2 of polynomial length N. ROM depth is 2^LOGN: lower half holds forward twiddles, upper half holds inverse twiddles.
- STAGE, 1, stage index, 1..LOGN. STAGE==0 is illegal (ROM-less stage needs no sequencer).
- DELAY_BROM, 2, ROM read latency in cycles, 1..8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that launches one polynomial pass
- intt  in  1  direction; sampled only on an accepted start
- in_valid  in  1  one input sample present this cycle; counter advances only when high
- raddr  out  LOGN  twiddle ROM read address
- tw_valid  out  1  ROM dout valid, aligned with dout
- tw_one  out  1  aligned with tw_valid; high marks pass-through half (twiddle multiply bypassed)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset values: raddr=0, tw_valid=0, tw_one=1, busy=0, done=0. FSM goes to IDLE, sample counter smp=0, delay lines cleared.
- Reset asserted mid-pass aborts the pass; no done pulse is emitted.
- FSM IDLE:
  - start accepted: latch intt into dir, smp=0, busy=1, go to RUN.
  - in_valid ignored.
- FSM RUN, each cycle with in_valid=1:
  - mul = smp[STAGE-1].
  - raddr = {dir, zeros, idx}, where idx = smp[STAGE-2:0] if mul, else 0. For STAGE==1, idx is empty and raddr = {dir, 0}.
  - Push (1, !mul) into the DELAY_BROM-deep (valid, one) delay line.
  - smp increments and wraps to 0 after N-1. The wrap cycle moves the FSM to FLUSH.
- FSM RUN, cycle with in_valid=0: raddr holds its value and a (0, 1) entry is pushed into the delay line.
- FSM FLUSH:
  - Push (0, 1) for DELAY_BROM cycles.
  - On the cycle the last valid entry leaves the line: assert done for one cycle, busy=0, return to IDLE.
- tw_valid/tw_one equal the delay-line output, i.e. the value presented DELAY_BROM cycles earlier.
- start while busy is ignored. No queuing; the controller must wait for done.
- start and done in the same cycle: done is issued, the start is ignored, and the block returns to IDLE.
- dir stays constant for the whole pass, even if intt toggles.
- Exactly N in_valid beats are consumed per pass and exactly N tw_valid beats are emitted.

Optional Feature:
- Macro: TW_ADDR_BITREV_EN.
- Defined: idx is the bit-reversal of smp[STAGE-2:0] over STAGE-1 bits. Use with ROMs stored in natural order.
- Undefined: idx = smp[STAGE-2:0] directly (ROMs stored pre-permuted).
- Latency, handshake and tw_one are identical in both builds.

Decomposition:
- Package tw_seq_pkg holds:
  - FSM state enum {IDLE, RUN, FLUSH}
  - localparam MAX_DELAY_BROM=8
  - helper function for the bit-reversal of a field
- One sub-module: tw_seq_dly, a parameterised DELAY_BROM-deep 2-bit shift register with synchronous clear.

Test Plan (LOGN=4, STAGE=3, DELAY_BROM=2 unless noted):
- Forward pass: start, intt=0, in_valid high 16 cycles.
  - raddr sequence = 0,0,0,0,0,1,2,3,0,0,0,0,0,1,2,3.
  - tw_one high for smp 0-3 and 8-11.
  - tw_valid high 16 cycles, starting 2 cycles after the first in_valid.
  - done pulses exactly once, 2 cycles after the last beat.
- Inverse pass: start with intt=1; toggle intt during the pass.
  - raddr = 8,8,8,8,8,9,10,11,...
  - dir does not change during the pass.
- Bubbles: in_valid pattern 1,0,1,1,0,... over 16 beats.
  - raddr holds its value during gaps.
  - Exactly 16 tw_valid beats, gaps mirrored with 2-cycle latency.
- Reset on beat 7: rst high 1 cycle.
  - All outputs return to reset values next cycle and no done is issued.
  - A new start then produces a clean full pass.
- start pulsed while busy at beat 5: ignored; pass completes normally with a single done.
- Sweeps:
  - STAGE=1: raddr always {dir,000}; tw_one high on even smp.
  - With TW_ADDR_BITREV_EN defined, STAGE=3: smp=5 gives raddr=2 and smp=6 gives raddr=1.
